// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the command record.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: one command -> one SETUP/ACCESS transfer -> one response.
// Latency: accept at edge N, rsp_valid in N+3 plus one cycle per wait state (abort at N+2+TIMEOUT).
// Backpressure: cmd_ready only in IDLE; response held with bus idle until rsp_ready.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: begin
                // cmd_ready comes up one cycle after reset release, then stays up until a command lands
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    wait_cnt_d  = '0;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == CNT_LAST) begin
                        state_d       = RESP;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a behavioural memory completer
// with programmable wait states, PSLVERR injection and a stuck-PREADY mode.
module tb_apb_master;
    import apb_pkg::*;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int          n_chk = 0;
    int          n_fail = 0;

    // completer model state
    logic [31:0] mem [0:255];
    int          wait_states = 0;
    int          wcnt = 0;
    logic        stuck = 1'b0;
    logic        err_inj = 1'b0;

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(clk), .PRESET(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    assign pready  = psel && penable && !stuck && (wcnt >= wait_states);
    assign prdata  = (psel && penable) ? mem[paddr] : 32'h0;
    assign pslverr = err_inj;

    always @(posedge clk) begin
        if (psel && penable) begin
            if (pready) begin
                if (pwrite) mem[paddr] <= pwdata;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle N+1 (first SETUP cycle).
    task automatic issue(input apb_cmd_t c);
        int g;
        g = 0;
        while (!cmd_ready && g < 50) begin
            step();
            g++;
        end
        check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        step();
        cmd_valid = 1'b0;
    endtask

    // Called in cycle N+1; returns k where rsp_valid first seen in cycle N+k.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            step();
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int       lat;
        logic     ok;
        logic [7:0]  a0;
        logic [31:0] d0;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h12345678;

        repeat (3) step();
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_psel_penable", {30'b0, psel, penable}, 32'd0);
        check("rst_paddr_pwdata", {24'b0, paddr} | pwdata, 32'd0);
        preset = 1'b0;
        step();
        step();
        check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // zero-wait write
        issue('{write: 1'b1, addr: 8'h04, wdata: 32'hDEADBEEF});
        check("wr_setup_psel_pen", {30'b0, psel, penable}, 32'b10);
        check("wr_setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        step();
        check("wr_access_psel_pen", {30'b0, psel, penable}, 32'b11);
        check("wr_pwdata", pwdata, 32'hDEADBEEF);
        check("wr_paddr_pwrite", {23'b0, pwrite, paddr}, {23'b0, 1'b1, 8'h04});
        step();
        check("wr_rsp_valid_n3", {31'b0, rsp_valid}, 32'd1);
        check("wr_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
        check("wr_resp_bus_idle", {30'b0, psel, penable}, 32'd0);
        take_rsp();

        // read back through the memory completer
        issue('{write: 1'b0, addr: 8'h04, wdata: 32'h0});
        wait_rsp(lat);
        check("rd_latency", lat, 32'd3);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        take_rsp();

        // three wait states
        wait_states = 3;
        issue('{write: 1'b0, addr: 8'h10, wdata: 32'h0});
        ok = 1'b1;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            if (paddr !== 8'h10) ok = 1'b0;
            step();
            lat++;
        end
        check("ws3_latency", lat, 32'd6);
        check("ws3_paddr_stable", {31'b0, ok}, 32'd1);
        check("ws3_rdata", rsp_rdata, 32'h12345678);
        take_rsp();
        wait_states = 0;

        // slave error
        err_inj = 1'b1;
        issue('{write: 1'b1, addr: 8'hFC, wdata: 32'hA5A5A5A5});
        wait_rsp(lat);
        check("slverr_latency", lat, 32'd3);
        check("slverr_err_to", {30'b0, rsp_err, rsp_timeout}, 32'b10);
        take_rsp();
        err_inj = 1'b0;

        // PREADY stuck low -> timeout abort; PRDATA is nonzero meanwhile
        stuck = 1'b1;
        issue('{write: 1'b0, addr: 8'h04, wdata: 32'h0});
        wait_rsp(lat);
        check("to_latency", lat, 32'd18);
        check("to_err_to", {30'b0, rsp_err, rsp_timeout}, 32'b11);
        check("to_rdata", rsp_rdata, 32'h0);
        take_rsp();
        stuck = 1'b0;

        issue('{write: 1'b0, addr: 8'h04, wdata: 32'h0});
        wait_rsp(lat);
        check("after_to_latency", lat, 32'd3);
        check("after_to_fields", {rsp_rdata[31:2], rsp_err, rsp_timeout}, {32'hDEADBEEF >> 2, 2'b00});
        take_rsp();

        // reset during ACCESS
        wait_states = 5;
        issue('{write: 1'b0, addr: 8'h10, wdata: 32'h0});
        step();
        check("mid_access_penable", {30'b0, psel, penable}, 32'b11);
        preset = 1'b1;
        step();
        check("mid_rst_psel_pen", {30'b0, psel, penable}, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        preset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0) ok = 1'b0;
            step();
        end
        check("mid_rst_no_rsp", {31'b0, ok}, 32'd1);
        wait_states = 0;

        // backpressure: response held for 10 cycles
        issue('{write: 1'b0, addr: 8'h10, wdata: 32'h0});
        wait_rsp(lat);
        check("bp_latency", lat, 32'd3);
        a0 = paddr;
        d0 = rsp_rdata;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 ||
                rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || psel !== 1'b0 ||
                penable !== 1'b0 || paddr !== a0 || rsp_rdata !== d0) ok = 1'b0;
            step();
        end
        check("bp_hold", {31'b0, ok}, 32'd1);
        take_rsp();
        check("bp_released_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_released_ready", {31'b0, cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
